systolic_link_tx: RTL and testbench

SYSTOLIC_LINK_TX -- requirements
Module: systolic_link_tx

---
 rtl/systolic_pkg.sv | 12 +
 rtl/systolic_lane_sel.sv | 29 ++
 rtl/systolic_link_tx.sv | 95 +++++++++
 tb/tb_systolic_link_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared systolic link definitions used by both the link transmitter and the tile.
// Word/lane geometry and the frame phase type live here so both sides agree.
package systolic_pkg;
    localparam int WORD_W = 16;
    localparam int NIB_W  = 4;
    localparam int PHASES = WORD_W / NIB_W;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_FIRST = 2'd0;
    localparam phase_t PH_LAST  = 2'd3;
endpackage

// File: rtl/systolic_lane_sel.sv
// Picks the nibble and control bit of a word for the current frame phase, MSB first.
// Latency: purely combinational.
// Backpressure: none, a pure selection function.
module systolic_lane_sel
    import systolic_pkg::phase_t;
#(
    parameter int WORD_W = systolic_pkg::WORD_W,
    parameter int NIB_W  = systolic_pkg::NIB_W,
    localparam int PHASES = WORD_W / NIB_W
) (
    input  logic [WORD_W-1:0] word,
    input  logic [PHASES-1:0] ctrl,
    input  phase_t            phase,
    output logic [NIB_W-1:0]  nib,
    output logic              ctrl_bit
);

    always_comb begin
        nib      = '0;
        ctrl_bit = 1'b0;
        for (int i = 0; i < PHASES; i++) begin
            if (phase == phase_t'(i)) begin
                nib      = word[WORD_W-1-NIB_W*i -: NIB_W];
                ctrl_bit = ctrl[PHASES-1-i];
            end
        end
    end

endmodule

// File: rtl/systolic_link_tx.sv
// Serialises row/column words into nibble lanes over a free-running 4-phase frame.
// Latency: 1 cycle (accepted at phase 3) up to 4 cycles (accepted at phase 0).
// Backpressure: in_ready drops while the one-entry holding buffer is occupied.
module systolic_link_tx
    import systolic_pkg::phase_t;
    import systolic_pkg::PH_FIRST;
    import systolic_pkg::PH_LAST;
#(
    parameter int WORD_W = systolic_pkg::WORD_W,
    parameter int NIB_W  = systolic_pkg::NIB_W,
    localparam int PHASES = WORD_W / NIB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_col_word,
    input  logic [WORD_W-1:0] in_row_word,
    input  logic [PHASES-1:0] in_col_ctrl,
    input  logic [PHASES-1:0] in_row_ctrl,
    output logic [NIB_W-1:0]  tx_col,
    output logic [NIB_W-1:0]  tx_row,
    output logic              tx_col_ctrl,
    output logic              tx_row_ctrl,
    output phase_t            phase,
    output logic              frame_start,
    output logic              tx_active
);

    typedef struct packed {
        logic [WORD_W-1:0] col_word;
        logic [WORD_W-1:0] row_word;
        logic [PHASES-1:0] col_ctrl;
        logic [PHASES-1:0] row_ctrl;
    } frame_t;

    frame_t in_frame;
    frame_t hold;
    frame_t frame;
    logic   hold_valid;
    logic   xfer;

    assign in_frame    = '{col_word: in_col_word, row_word: in_row_word,
                           col_ctrl: in_col_ctrl, row_ctrl: in_row_ctrl};
    assign in_ready    = !hold_valid;
    assign xfer        = in_valid && in_ready;
    assign frame_start = (phase == PH_FIRST);

    // Frame registers change only on the last-phase edge so a frame is never torn;
    // an offer arriving exactly then skips the holding buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= PH_FIRST;
            hold       <= '0;
            hold_valid <= 1'b0;
            frame      <= '0;
            tx_active  <= 1'b0;
        end else begin
            phase <= phase + 2'd1;
            if (phase == PH_LAST) begin
                if (hold_valid) begin
                    frame      <= hold;
                    hold_valid <= 1'b0;
                    tx_active  <= 1'b1;
                end else if (xfer) begin
                    frame     <= in_frame;
                    tx_active <= 1'b1;
                end else begin
                    frame     <= '0;
                    tx_active <= 1'b0;
                end
            end else if (xfer) begin
                hold       <= in_frame;
                hold_valid <= 1'b1;
            end
        end
    end

    systolic_lane_sel #(.WORD_W(WORD_W), .NIB_W(NIB_W)) u_col_sel (
        .word     (frame.col_word),
        .ctrl     (frame.col_ctrl),
        .phase    (phase),
        .nib      (tx_col),
        .ctrl_bit (tx_col_ctrl)
    );

    systolic_lane_sel #(.WORD_W(WORD_W), .NIB_W(NIB_W)) u_row_sel (
        .word     (frame.row_word),
        .ctrl     (frame.row_ctrl),
        .phase    (phase),
        .nib      (tx_row),
        .ctrl_bit (tx_row_ctrl)
    );

endmodule

// File: tb/tb_systolic_link_tx.sv
// Directed table-driven bench for systolic_link_tx plus hand sequences for
// mid-frame acceptance and mid-frame reset.
module tb_systolic_link_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_col_word;
    logic [15:0] in_row_word;
    logic [3:0]  in_col_ctrl;
    logic [3:0]  in_row_ctrl;
    logic [3:0]  tx_col;
    logic [3:0]  tx_row;
    logic        tx_col_ctrl;
    logic        tx_row_ctrl;
    logic [1:0]  phase;
    logic        frame_start;
    logic        tx_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_link_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_col_word (in_col_word),
        .in_row_word (in_row_word),
        .in_col_ctrl (in_col_ctrl),
        .in_row_ctrl (in_row_ctrl),
        .tx_col      (tx_col),
        .tx_row      (tx_row),
        .tx_col_ctrl (tx_col_ctrl),
        .tx_row_ctrl (tx_row_ctrl),
        .phase       (phase),
        .frame_start (frame_start),
        .tx_active   (tx_active)
    );

    typedef struct {
        logic        vld;
        logic [15:0] col;
        logic [15:0] row;
        logic [3:0]  cc;
        logic [3:0]  rc;
        logic [1:0]  e_ph;
        logic [3:0]  e_col;
        logic [3:0]  e_row;
        logic        e_cc;
        logic        e_rc;
        logic        e_act;
        logic        e_rdy;
    } vec_t;

    localparam int NV = 28;
    vec_t vt[NV];

    function automatic vec_t mk(logic vld, logic [15:0] col, logic [15:0] row,
                                logic [3:0] cc, logic [3:0] rc, logic [1:0] e_ph,
                                logic [3:0] e_col, logic [3:0] e_row, logic e_cc,
                                logic e_rc, logic e_act, logic e_rdy);
        vec_t v;
        v.vld = vld; v.col = col; v.row = row; v.cc = cc; v.rc = rc;
        v.e_ph = e_ph; v.e_col = e_col; v.e_row = e_row; v.e_cc = e_cc;
        v.e_rc = e_rc; v.e_act = e_act; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_col, input logic [3:0] e_row,
                           input logic e_cc, input logic e_rc, input logic [1:0] e_ph,
                           input logic e_act, input logic e_rdy);
        chk({tag, ".tx_col"},      16'(tx_col),      16'(e_col));
        chk({tag, ".tx_row"},      16'(tx_row),      16'(e_row));
        chk({tag, ".tx_col_ctrl"}, 16'(tx_col_ctrl), 16'(e_cc));
        chk({tag, ".tx_row_ctrl"}, 16'(tx_row_ctrl), 16'(e_rc));
        chk({tag, ".phase"},       16'(phase),       16'(e_ph));
        chk({tag, ".frame_start"}, 16'(frame_start), 16'(e_ph == 2'd0));
        chk({tag, ".tx_active"},   16'(tx_active),   16'(e_act));
        chk({tag, ".in_ready"},    16'(in_ready),    16'(e_rdy));
    endtask

    task automatic drive(input logic vld, input logic [15:0] col, input logic [15:0] row,
                         input logic [3:0] cc, input logic [3:0] rc);
        in_valid = vld; in_col_word = col; in_row_word = row;
        in_col_ctrl = cc; in_row_ctrl = rc;
    endtask

    initial begin
        logic [3:0] a_col[4];
        logic [3:0] a_row[4];
        logic       a_cc[4];
        logic       a_rc[4];
        logic       k_cc[4];
        logic       k_rc[4];
        logic [3:0] p_col[4];
        logic [3:0] p_row[4];
        logic       p_cc[4];
        logic       p_rc[4];

        // Frame 0xA5C3 / 0x1234, ctrl 1001 / 0110.
        a_col = '{4'hA, 4'h5, 4'hC, 4'h3};
        a_row = '{4'h1, 4'h2, 4'h3, 4'h4};
        a_cc  = '{1'b1, 1'b0, 1'b0, 1'b1};
        a_rc  = '{1'b0, 1'b1, 1'b1, 1'b0};
        // Streamed frames use ctrl 1100 / 0011.
        k_cc  = '{1'b1, 1'b1, 1'b0, 1'b0};
        k_rc  = '{1'b0, 1'b0, 1'b1, 1'b1};
        // Frame 0x8421 / 0x0F0F, ctrl 0101 / 1010.
        p_col = '{4'h8, 4'h4, 4'h2, 4'h1};
        p_row = '{4'h0, 4'hF, 4'h0, 4'hF};
        p_cc  = '{1'b0, 1'b1, 1'b0, 1'b1};
        p_rc  = '{1'b1, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 3; i++)
            vt[i] = mk(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 2'(i), 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[3] = mk(1'b1, 16'hA5C3, 16'h1234, 4'b1001, 4'b0110, 2'd3,
                   4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 4; p++)
            vt[4+p] = mk(1'b1, 16'h1111, 16'h5555, 4'b1100, 4'b0011, 2'(p),
                         a_col[p], a_row[p], a_cc[p], a_rc[p], 1'b1, p == 0);
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 4; p++) begin
                logic [15:0] nc;
                logic [15:0] nr;
                logic        nv;
                nv = (f < 2);
                nc = (f == 0) ? 16'h2222 : (f == 1) ? 16'h3333 : 16'h0000;
                nr = (f == 0) ? 16'h6666 : (f == 1) ? 16'h7777 : 16'h0000;
                vt[8+4*f+p] = mk(nv, nc, nr, nv ? 4'b1100 : 4'b0000, nv ? 4'b0011 : 4'b0000,
                                 2'(p), 4'(f+1), 4'(f+5), k_cc[p], k_rc[p], 1'b1,
                                 (p == 0) || (f == 2));
            end
        end
        for (int i = 20; i < 28; i++)
            vt[i] = mk(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 2'(i % 4), 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset state.
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Table: check the current cycle, then drive the inputs for the next edge.
        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            chk_out($sformatf("vec%0d", i), vt[i].e_col, vt[i].e_row, vt[i].e_cc, vt[i].e_rc,
                    vt[i].e_ph, vt[i].e_act, vt[i].e_rdy);
            drive(vt[i].vld, vt[i].col, vt[i].row, vt[i].cc, vt[i].rc);
        end

        // Offer at phase 1: held until the phase-3 edge, appears at the next phase 0.
        @(negedge clk);  // cycle 28, phase 0
        chk_out("mid.p0", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        @(negedge clk);  // phase 1
        drive(1'b1, 16'h8421, 16'h0F0F, 4'b0101, 4'b1010);
        @(negedge clk);  // phase 2
        drive(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        chk_out("mid.p2", 4'h0, 4'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
        @(negedge clk);  // phase 3
        chk_out("mid.p3", 4'h0, 4'h0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            chk_out($sformatf("mid.out%0d", p), p_col[p], p_row[p], p_cc[p], p_rc[p],
                    2'(p), 1'b1, 1'b1);
            // At phase 3 offer 0xBEEF so it bypasses straight into the next frame.
            if (p == 3) drive(1'b1, 16'hBEEF, 16'hCAFE, 4'b1111, 4'b0000);
        end

        // Mid-frame reset with a second frame sitting in the holding buffer.
        @(negedge clk);  // phase 0 of 0xBEEF
        chk_out("rst.p0", 4'hB, 4'hC, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
        drive(1'b1, 16'h7777, 16'h7777, 4'b1111, 4'b1111);
        @(negedge clk);  // phase 1, 0x7777 held
        drive(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        chk_out("rst.p1", 4'hE, 4'hA, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        @(negedge clk);  // phase 2
        chk_out("rst.p2", 4'hE, 4'hF, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_out("rst.asserted", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk_out("rst.held", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        chk_out("rst.release", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            chk_out($sformatf("rst.after%0d", i), 4'h0, 4'h0, 1'b0, 1'b0, 2'(i % 4), 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
